// File: rtl/elevator_call_panel.sv
`default_nettype none
// ============================================================================
// Module   : elevator_call_panel
// Purpose  : Call-side companion to the elevator controller. Synchronises and
//            debounces raw per-floor call buttons, latches each accepted press
//            as a pending request, clears a request when the car stands at
//            that floor with the door open, times the door-open/wait phases
//            and flags a door that stays open too long.
// Ports    : clk           - clock
//            reset         - asynchronous active-high reset
//            btn           - raw call buttons, one per floor (asynchronous)
//            door          - door-open indication from the controller
//            motor_dir     - 00 stopped, 01 up, 10 down
//            current_floor - car position
//            req_floor     - pending requests, one bit per floor (registered)
//            lamp          - call-acknowledge lamps (mirror of req_floor)
//            pending       - any request pending
//            timer_expired - one-cycle pulse at the end of each door phase
//            door_fault    - sticky door-stuck flag
// Revision : 1.0 - initial release
// ============================================================================
module elevator_call_panel #(
  parameter int NUM_FLOORS      = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DOOR_CYCLES     = 8,
  parameter int MAX_DOOR_PHASES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic                  door,
  input  logic [1:0]            motor_dir,
  input  logic [1:0]            current_floor,
  output logic [NUM_FLOORS-1:0] req_floor,
  output logic [NUM_FLOORS-1:0] lamp,
  output logic                  pending,
  output logic                  timer_expired,
  output logic                  door_fault
);

  localparam int DC_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TC_W = $clog2(DOOR_CYCLES);
  localparam int PC_W = ($clog2(MAX_DOOR_PHASES + 1) < 1) ? 1 : $clog2(MAX_DOOR_PHASES + 1);

  localparam logic [DC_W-1:0] DC_MAX  = DC_W'(DEBOUNCE_CYCLES);
  localparam logic [DC_W-1:0] DC_ARM  = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(DOOR_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_MAX  = PC_W'(MAX_DOOR_PHASES);

  logic [NUM_FLOORS-1:0] sync_meta;
  logic [NUM_FLOORS-1:0] sync_out;
  logic [DC_W-1:0]       dc [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] set_req;
  logic [NUM_FLOORS-1:0] clr_req;

  logic [TC_W-1:0]       tc;
  logic [PC_W-1:0]       pc;
  logic                  phase_end;

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= btn;
      sync_out  <= sync_meta;
    end
  end

  generate
    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
      logic here;

      // Saturating run-length counter; the press fires on the single cycle
      // the run reaches DEBOUNCE_CYCLES, so a held button yields one event.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dc[i] <= '0;
        end else if (!sync_out[i]) begin
          dc[i] <= '0;
        end else if (dc[i] != DC_MAX) begin
          dc[i] <= dc[i] + 1'b1;
        end
      end

      // Out-of-range floor codes never match any bit
      assign here       = (current_floor == 2'(i));
      assign press[i]   = sync_out[i] && (dc[i] == DC_ARM);
      // A car already standing at this floor absorbs the call
      assign set_req[i] = press[i] && !((motor_dir == 2'b00) && here);
      assign clr_req[i] = door && here;
    end
  endgenerate

  // Clear has priority over set for the same bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_floor <= '0;
    end else begin
      req_floor <= (req_floor | set_req) & ~clr_req;
    end
  end

  assign lamp    = req_floor;
  assign pending = |req_floor;

  assign phase_end = door && (tc == TC_LAST);

  // Door phase timer and stuck-door supervision. The phase counter is
  // advanced on the same edge that launches the pulse, so the fault flag
  // rises together with the offending pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc            <= '0;
      pc            <= '0;
      timer_expired <= 1'b0;
      door_fault    <= 1'b0;
    end else begin
      timer_expired <= phase_end;
      if (!door) begin
        tc <= '0;
        pc <= '0;
      end else begin
        tc <= phase_end ? '0 : tc + 1'b1;
        if (phase_end) begin
          if (pc == PC_MAX) begin
            door_fault <= 1'b1;
          end else begin
            pc <= pc + 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elevator_call_panel.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_call_panel
// Purpose  : Self-checking bench for elevator_call_panel. A behavioural model
//            tracks button run lengths and door-open durations and is compared
//            against the DUT after every clock edge; directed steps pin key
//            values with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_call_panel;

  localparam int NF   = 3;
  localparam int DEB  = 4;
  localparam int DOOR = 8;
  localparam int MAXP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] btn;
  logic          door;
  logic [1:0]    motor_dir;
  logic [1:0]    current_floor;
  logic [NF-1:0] req_floor;
  logic [NF-1:0] lamp;
  logic          pending;
  logic          timer_expired;
  logic          door_fault;

  int n_checks = 0;
  int n_fail   = 0;

  elevator_call_panel #(
    .NUM_FLOORS      (NF),
    .DEBOUNCE_CYCLES (DEB),
    .DOOR_CYCLES     (DOOR),
    .MAX_DOOR_PHASES (MAXP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .door          (door),
    .motor_dir     (motor_dir),
    .current_floor (current_floor),
    .req_floor     (req_floor),
    .lamp          (lamp),
    .pending       (pending),
    .timer_expired (timer_expired),
    .door_fault    (door_fault)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [NF-1:0] m_stage1, m_stage2;   // button samples delayed by one and two edges
  int            m_run [NF];           // consecutive high synchronised samples
  logic [NF-1:0] m_req;
  int            m_open;               // edges the door has been seen open in a row
  logic          m_te;
  logic          m_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_stage1 = '0;
      m_stage2 = '0;
      for (int i = 0; i < NF; i++) m_run[i] = 0;
      m_req   = '0;
      m_open  = 0;
      m_te    = 1'b0;
      m_fault = 1'b0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        logic accepted;
        m_run[i] = m_stage2[i] ? m_run[i] + 1 : 0;
        accepted = (m_run[i] == DEB);
        if (door && int'(current_floor) == i)
          m_req[i] = 1'b0;
        else if (accepted && !(motor_dir == 2'b00 && int'(current_floor) == i))
          m_req[i] = 1'b1;
      end
      m_stage2 = m_stage1;
      m_stage1 = btn;
      m_open = door ? m_open + 1 : 0;
      m_te   = door && (m_open % DOOR == 0);
      if (m_open / DOOR > MAXP) m_fault = 1'b1;
    end
    #1;
    check("req_floor",     32'(req_floor),     32'(m_req));
    check("lamp",          32'(lamp),          32'(m_req));
    check("pending",       32'(pending),       32'(|m_req));
    check("timer_expired", 32'(timer_expired), 32'(m_te));
    check("door_fault",    32'(door_fault),    32'(m_fault));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; btn = '0; door = 1'b0; motor_dir = 2'b00; current_floor = 2'd0;
    tick(2);
    check("reset req_floor", 32'(req_floor), 32'h0);
    check("reset timer", 32'(timer_expired), 32'h0);
    check("reset fault", 32'(door_fault), 32'h0);
    reset = 1'b0;
    tick(1);

    // Debounced press: rises 6 cycles after the first sample
    btn = 3'b100;
    tick(5);
    check("press latency early", 32'(req_floor), 32'h0);
    tick(1);
    check("press latency", 32'(req_floor), 32'h4);
    check("press pending", 32'(pending), 32'h1);
    tick(4);
    btn = 3'b000;
    tick(2);
    // 3-cycle glitch is shorter than the debounce window
    btn = 3'b010;
    tick(3);
    btn = 3'b000;
    tick(8);
    check("glitch ignored", 32'(req_floor), 32'h4);

    // Service clear at floor 2 and absorption during the door interval
    current_floor = 2'd2; door = 1'b1;
    tick(1);
    check("service clear", 32'(req_floor), 32'h0);
    btn = 3'b100;
    tick(7);
    btn = 3'b000;
    tick(1);
    check("press absorbed", 32'(req_floor), 32'h0);
    door = 1'b0;
    tick(3);

    // Door timer: pulses at 8 and 16 after door rise
    door = 1'b1;
    tick(7);
    check("timer before 8", 32'(timer_expired), 32'h0);
    tick(1);
    check("timer at 8", 32'(timer_expired), 32'h1);
    tick(1);
    check("timer width", 32'(timer_expired), 32'h0);
    tick(7);
    check("timer at 16", 32'(timer_expired), 32'h1);
    tick(4);
    door = 1'b0;
    tick(10);
    check("timer stopped", 32'(timer_expired), 32'h0);
    check("no fault short", 32'(door_fault), 32'h0);

    // Stationary drop, then moving latch
    current_floor = 2'd1; motor_dir = 2'b00;
    btn = 3'b010;
    tick(8);
    btn = 3'b000;
    tick(3);
    check("stationary drop", 32'(req_floor), 32'h0);
    motor_dir = 2'b01;
    btn = 3'b010;
    tick(8);
    btn = 3'b000;
    tick(2);
    check("moving latch", 32'(req_floor), 32'h2);
    btn = 3'b001;
    tick(8);
    btn = 3'b000;
    tick(2);
    check("two pending", 32'(req_floor), 32'h3);

    // Door fault with an out-of-range floor (clears nothing)
    motor_dir = 2'b00; current_floor = 2'd3; door = 1'b1;
    tick(39);
    check("fault before 5th", 32'(door_fault), 32'h0);
    tick(1);
    check("fault at 5th", 32'(door_fault), 32'h1);
    check("5th pulse", 32'(timer_expired), 32'h1);
    tick(2);
    door = 1'b0;
    tick(3);
    check("fault sticky", 32'(door_fault), 32'h1);
    check("out of range keeps", 32'(req_floor), 32'h3);

    // Mid-operation reset with tc mid-count
    door = 1'b1;
    tick(3);
    reset = 1'b1; door = 1'b0;
    #1;
    check("async reset req", 32'(req_floor), 32'h0);
    check("async reset fault", 32'(door_fault), 32'h0);
    check("async reset pending", 32'(pending), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(2);
    door = 1'b1;
    tick(7);
    check("post-reset timer early", 32'(timer_expired), 32'h0);
    tick(1);
    check("post-reset timer full", 32'(timer_expired), 32'h1);
    door = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
